// File: rtl/float_subtractor_seq_if.sv
// float_subtractor_seq_if: valid/ready operand channel and result channel
// for the iterative FP32 subtractor.
interface float_subtractor_seq_if;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, out;
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, out);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/float_subtractor_seq.sv
// float_subtractor_seq: iterative FP32 subtractor, out = a - b.
// Alignment and normalisation advance one bit per cycle; truncating, no guard/sticky bits.
module float_subtractor_seq #(
   parameter int ALIGN_CAP = 24
) (
   input logic                   clk,
   input logic                   rst_n,
   float_subtractor_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ALIGN, ARITH, NORM, DONE} state_t;
   localparam logic [7:0] CAP = 8'(ALIGN_CAP);
   state_t      r_state, w_next;
   logic        r_sgn_big, r_sgn_small, r_sign;
   logic [8:0]  r_exp;
   logic [7:0]  r_diff;
   logic [24:0] r_mb, r_ms, r_mant;
   logic [31:0] r_out;
   logic        w_sa, w_sb, w_a_big, w_far;
   logic [7:0]  w_ea, w_eb, w_dab;
   logic [24:0] w_ma, w_mbb;
   logic [8:0]  w_exp_inc;
   // zero exponent field unpacks as exponent 1 with hidden bit 0
   assign w_sa      = bus.a[31];
   assign w_sb      = ~bus.b[31];
   assign w_ea      = bus.a[30:23] == 8'd0 ? 8'd1 : bus.a[30:23];
   assign w_eb      = bus.b[30:23] == 8'd0 ? 8'd1 : bus.b[30:23];
   assign w_ma      = {1'b0, bus.a[30:23] != 8'd0, bus.a[22:0]};
   assign w_mbb     = {1'b0, bus.b[30:23] != 8'd0, bus.b[22:0]};
   assign w_a_big   = w_ea >= w_eb;
   assign w_dab     = w_a_big ? w_ea - w_eb : w_eb - w_ea;
   assign w_far     = w_dab > CAP;
   assign w_exp_inc = r_exp + 9'd1;
   assign bus.in_ready  = r_state == IDLE;
   assign bus.out_valid = r_state == DONE;
   assign bus.out       = r_out;
   always_ff @(posedge clk)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.in_valid ? ALIGN : IDLE;
         ALIGN:   w_next = r_diff == 8'd0 ? ARITH : ALIGN;
         ARITH:   w_next = NORM;
         NORM:    w_next = (r_mant != '0 && !r_mant[24] && !r_mant[23] && r_exp > 9'd1) ? NORM : DONE;
         DONE:    w_next = bus.out_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sgn_big <= 1'b0; r_sgn_small <= 1'b0; r_sign <= 1'b0;
         r_exp <= '0; r_diff <= '0; r_mb <= '0; r_ms <= '0; r_mant <= '0; r_out <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_sgn_big   <= w_a_big ? w_sa : w_sb;
               r_sgn_small <= w_a_big ? w_sb : w_sa;
               r_exp       <= {1'b0, w_a_big ? w_ea : w_eb};
               r_mb        <= w_a_big ? w_ma : w_mbb;
               r_ms        <= w_far ? '0 : (w_a_big ? w_mbb : w_ma);
               r_diff      <= w_far ? '0 : w_dab;
            end
            ALIGN: if (r_diff != 8'd0) begin
               r_ms   <= r_ms >> 1;
               r_diff <= r_diff - 8'd1;
            end
            ARITH: begin
               r_mant <= r_sgn_big == r_sgn_small ? r_mb + r_ms : (r_mb >= r_ms ? r_mb - r_ms : r_ms - r_mb);
               r_sign <= (r_sgn_big != r_sgn_small && r_mb < r_ms) ? r_sgn_small : r_sgn_big;
            end
            NORM: begin
               if (r_mant == '0) r_out <= '0;
               else if (r_mant[24]) r_out <= w_exp_inc >= 9'd255 ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_exp_inc[7:0], r_mant[23:1]};
               else if (!r_mant[23] && r_exp > 9'd1) begin
                  r_mant <= r_mant << 1;
                  r_exp  <= r_exp - 9'd1;
               end
               else r_out <= {r_sign, r_mant[23] ? r_exp[7:0] : 8'd0, r_mant[22:0]};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_float_subtractor_seq.sv
// tb_float_subtractor_seq: directed and random vectors against a signed-integer
// reference of a - b, checking results, latency, backpressure and mid-op reset.
module tb_float_subtractor_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   int   n_vec = 0, n_err = 0;
   float_subtractor_seq_if bus();
   float_subtractor_seq #(.ALIGN_CAP(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // signed-magnitude arithmetic on the unpacked values, then normalise
   task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output int lat);
      int ex, ey, eb, d, e;
      longint vx, vy, vb, vs, s, m;
      bit neg;
      ex = x[30:23] == 8'd0 ? 1 : int'(x[30:23]);
      ey = y[30:23] == 8'd0 ? 1 : int'(y[30:23]);
      vx = longint'({x[30:23] != 8'd0, x[22:0]});
      vy = longint'({y[30:23] != 8'd0, y[22:0]});
      if (x[31]) vx = -vx;
      if (!y[31]) vy = -vy;
      if (ex >= ey) begin eb = ex; d = ex - ey; vb = vx; vs = vy; end
      else          begin eb = ey; d = ey - ex; vb = vy; vs = vx; end
      if (d > 24) begin vs = 0; d = 0; end
      else vs = vs < 0 ? -((-vs) >> d) : vs >> d;
      lat = 3 + d;
      s = vb + vs;
      neg = s < 0;
      m = neg ? -s : s;
      e = eb;
      if (m == 0) r = 32'd0;
      else if (m >= 64'd16777216) begin
         e++;
         r = e >= 255 ? {neg, 8'hFF, 23'd0} : {neg, 8'(e), 23'(m >> 1)};
      end else begin
         while (m < 64'd8388608 && e > 1) begin m = m << 1; e--; lat++; end
         r = {neg, m >= 64'd8388608 ? 8'(e) : 8'd0, 23'(m)};
      end
   endtask

   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int hold);
      logic [31:0] r;
      int lat, cyc;
      model(x, y, r, lat);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
      bus.a = x; bus.b = y; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom;
      cyc = 0;
      do begin @(posedge clk); #1 cyc++; end while (!bus.out_valid && cyc < 200);
      chk($sformatf("lat %h-%h", x, y), 32'(cyc), 32'(lat));
      chk($sformatf("out %h-%h", x, y), bus.out, r);
      repeat (hold) begin
         bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_out", bus.out, r);
         chk("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("drop_valid", 32'(bus.out_valid), 32'd0);
   endtask

   logic [31:0] da [9] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000,
                           32'h4B800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hC0400000};
   logic [31:0] db [9] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F7FFFFF, 32'h00000001,
                           32'h3F800000, 32'h3F800000, 32'hFF7FFFFF, 32'h40800000};
   logic [31:0] ka [8] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h34000000, 32'h007FFFFF,
                           32'h4B800000, 32'h7F7FFFFF, 32'h7F800000};

   initial begin
      logic [31:0] r, x, y;
      int lat, seen;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out", bus.out, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         model(da[i], db[i], r, lat);
         chk($sformatf("ref%0d", i), r, ka[i]);
      end
      do_op(da[0], db[0], 5);
      for (int i = 1; i < 9; i++) do_op(da[i], db[i], 0);
      bus.a = 32'h4B800000; bus.b = 32'h3F800000; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_out", bus.out, 32'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin @(posedge clk); #1 if (bus.out_valid) seen = 1; end
      chk("stale", 32'(seen), 32'd0);
      for (int i = 0; i < 60; i++) begin
         x = $urandom; y = $urandom;
         if (i % 2 == 1) y[30:23] = x[30:23] - 8'($urandom_range(0, 3));
         if (i % 5 == 0) y[30:23] = x[30:23] - 8'($urandom_range(20, 30));
         do_op(x, y, i % 7 == 0 ? 2 : 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
